// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter (start, DATA_W bits LSB first, STOP_BITS stop bits).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_core #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_done;
    logic              w_last;
    logic              w_accept;
    logic              w_data_end;
    logic              w_stop_end;

    assign w_last     = r_cnt == CW'(CLKS_PER_BIT - 1);
    assign w_accept   = tx_valid && r_state == IDLE;
    assign w_data_end = w_last && r_bit == 4'(DATA_W - 1);
    assign w_stop_end = w_last && r_bit == 4'(STOP_BITS - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (tx_valid) w_next = START;
            START:   if (w_last) w_next = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:    if (w_data_end) w_next = PARITY;
            PARITY:  if (w_last) w_next = STOP;
`else
            DATA:    if (w_data_end) w_next = STOP;
`endif
            STOP:    if (w_stop_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // r_bit counts data bits in DATA and stop bits in STOP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_state == STOP && w_stop_end;
            r_cnt  <= (r_state == IDLE || w_last) ? '0 : r_cnt + 1'b1;
            if (w_accept)
                r_shift <= tx_data;
            else if (r_state == DATA && w_last)
                r_shift <= r_shift >> 1;
            if ((r_state == DATA && w_data_end) || (r_state == STOP && w_stop_end))
                r_bit <= '0;
            else if (w_last && (r_state == DATA || r_state == STOP))
                r_bit <= r_bit + 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_par <= 1'b0;
        else if (w_accept) r_par <= ^tx_data ^ 1'(PARITY_ODD);
    end

    assign tx = r_state == START  ? 1'b0 :
                r_state == DATA   ? r_shift[0] :
                r_state == PARITY ? r_par : 1'b1;
`else
    assign tx = r_state == START ? 1'b0 :
                r_state == DATA  ? r_shift[0] : 1'b1;
`endif

    assign busy     = r_state != IDLE;
    assign tx_ready = r_state == IDLE;
    assign done     = r_done;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: three uart_tx_core configurations on shared stimulus, each checked
// cycle by cycle against a frame built from the serial-format rules.
module tb_uart_tx_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [8:0] tx_data = '0;
    logic [2:0] tx_w, busy_w, done_w, rdy_w;
    int         total = 0;
    int         bad = 0;
    bit         exp_q[$];

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .reset(reset), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx_core #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
        .clk(clk), .reset(reset), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx_core #(.DATA_W(9), .CLKS_PER_BIT(2), .STOP_BITS(1), .PARITY_ODD(0)) u_c (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    function automatic int dw(int s);  return s == 2 ? 9 : 8; endfunction
    function automatic int cpb(int s); return s == 2 ? 2 : 4; endfunction
    function automatic int sb(int s);  return s == 1 ? 2 : 1; endfunction
    function automatic int po(int s);  return s == 1 ? 1 : 0; endfunction
    function automatic logic [8:0] msk(int s); return s == 2 ? 9'h1FF : 9'h0FF; endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected tx level for every cycle of one frame
    task automatic build(int s, logic [8:0] d);
        exp_q.delete();
        repeat (cpb(s)) exp_q.push_back(1'b0);
        for (int b = 0; b < dw(s); b++) repeat (cpb(s)) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
        begin
            bit p;
            p = bit'(($countones(d & msk(s)) % 2) ^ po(s));
            repeat (cpb(s)) exp_q.push_back(p);
        end
`endif
        repeat (cpb(s) * sb(s)) exp_q.push_back(1'b1);
    endtask

    task automatic idle_all();
        int n = 0;
        tx_valid = 1'b0;
        @(negedge clk);
        while (rdy_w != 3'b111 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", {29'd0, rdy_w}, 32'd7);
        @(negedge clk);
    endtask

    task automatic start(logic [8:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
    endtask

    // called at the negedge of frame cycle 0; tx_valid stays high while busy
    task automatic check_frame(int s, logic [8:0] d, bit chain, logic [8:0] nd);
        build(s, d);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tx%0d_c%0d", s, i), {31'd0, tx_w[s]}, {31'd0, exp_q[i]});
            chk($sformatf("busy%0d_c%0d", s, i), {31'd0, busy_w[s]}, 32'd1);
            chk($sformatf("rdy%0d_c%0d", s, i), {31'd0, rdy_w[s]}, 32'd0);
            chk($sformatf("done%0d_c%0d", s, i), {31'd0, done_w[s]}, 32'd0);
            if (i == 0) tx_data = ~d;
            if (i == exp_q.size() - 1) begin
                tx_valid = chain;
                tx_data  = nd;
            end
        end
        @(negedge clk);
        chk($sformatf("done%0d_pulse", s), {31'd0, done_w[s]}, 32'd1);
        chk($sformatf("rdy%0d_at_done", s), {31'd0, rdy_w[s]}, 32'd1);
        chk($sformatf("tx%0d_at_done", s), {31'd0, tx_w[s]}, 32'd1);
        chk($sformatf("busy%0d_at_done", s), {31'd0, busy_w[s]}, 32'd0);
        if (!chain) begin
            @(negedge clk);
            chk($sformatf("done%0d_one_cycle", s), {31'd0, done_w[s]}, 32'd0);
        end
    endtask

    task automatic send(int s, logic [8:0] d);
        idle_all();
        start(d);
        check_frame(s, d, 1'b0, 9'h0);
    endtask

    initial begin
        #1;
        chk("rst_tx", {29'd0, tx_w}, 32'd7);
        chk("rst_busy", {29'd0, busy_w}, 32'd0);
        chk("rst_done", {29'd0, done_w}, 32'd0);
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ignore_valid", {29'd0, busy_w}, 32'd0);
        tx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdy", {29'd0, rdy_w}, 32'd7);
        chk("rst_tx_idle", {29'd0, tx_w}, 32'd7);

        send(0, 9'h0A5);
        send(0, 9'h007);
        send(1, 9'h0A5);
        send(2, 9'h1FF);

        idle_all();
        start(9'h000);
        check_frame(1, 9'h000, 1'b1, 9'h0FF);
        @(negedge clk);
        check_frame(1, 9'h0FF, 1'b0, 9'h0);

        idle_all();
        start(9'h03C);
        build(0, 9'h03C);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("abort_tx_c%0d", i), {31'd0, tx_w[0]}, {31'd0, exp_q[i]});
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("async_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("async_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("async_done", {31'd0, done_w[0]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold_busy", {31'd0, busy_w[0]}, 32'd0);
        end
        tx_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done_w[0]}, 32'd0);
            chk("abort_tx_high", {31'd0, tx_w[0]}, 32'd1);
        end
        chk("abort_rdy", {31'd0, rdy_w[0]}, 32'd1);

        for (int k = 0; k < 12; k++) begin
            int         s;
            bit         ch;
            logic [8:0] d, nd;
            s  = $urandom_range(0, 2);
            ch = 1'($urandom_range(0, 1));
            d  = 9'($urandom) & msk(s);
            nd = 9'($urandom) & msk(s);
            idle_all();
            start(d);
            check_frame(s, d, ch, nd);
            if (ch) begin
                @(negedge clk);
                check_frame(s, nd, 1'b0, 9'h0);
            end
        end

        idle_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
